// File: rtl/hwpe_stream_traffic_sched.sv
// Scheduler for a bank of HWPE-Stream traffic generators: concurrent, round-robin
// burst, sequential or forced-valid traffic, with per-generator LFSR stall numbers.
module hwpe_stream_traffic_sched #(
  parameter int          NB_GEN    = 4,
  parameter int          BURST_LEN = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         AW        = (NB_GEN > 1) ? $clog2(NB_GEN) : 1,
  localparam int         CW        = $clog2(BURST_LEN + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [1:0]             mode_i,
  input  logic                   randomize_i,
  input  logic [NB_GEN-1:0]      fire_i,
  input  logic [NB_GEN-1:0]      eot_i,
  output logic [NB_GEN-1:0]      force_invalid_o,
  output logic [NB_GEN-1:0]      force_valid_o,
  output logic [NB_GEN*32-1:0]   rng_o,
  output logic                   randomize_o,
  output logic [AW-1:0]          active_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   proto_err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [1:0] M_CONC = 2'd0, M_RR = 2'd1, M_SEQ = 2'd2, M_FORCE = 2'd3;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       active_d;
  logic                rand_d, proto_d, beat;
  logic [NB_GEN-1:0]   en_d, fv_d, en_prev_q, en_q;

  // First non-eot index strictly after cur, wrapping; cur itself is the last resort.
  function automatic logic [AW-1:0] next_gen(input logic [AW-1:0] cur,
                                             input logic [NB_GEN-1:0] eot);
    logic [AW-1:0] res;
    int idx;
    res = cur;
    for (int k = NB_GEN; k >= 1; k--) begin
      idx = (int'(cur) + k) % NB_GEN;
      if (!eot[AW'(idx)]) res = AW'(idx);
    end
    return res;
  endfunction

  function automatic logic [AW-1:0] lowest_gen(input logic [NB_GEN-1:0] eot);
    logic [AW-1:0] res;
    res = '0;
    for (int i = NB_GEN - 1; i >= 0; i--)
      if (!eot[AW'(i)]) res = AW'(i);
    return res;
  endfunction

  assign en_q = ~force_invalid_o;
  assign beat = fire_i[active_o];

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    active_d = active_o;
    rand_d   = randomize_o;
    proto_d  = proto_err_o;
    case (state_q)
      IDLE: if (start_i) begin
        mode_d   = mode_i;
        rand_d   = randomize_i;
        cnt_d    = '0;
        proto_d  = 1'b0;
        active_d = (mode_i == M_RR || mode_i == M_SEQ) ? lowest_gen(eot_i) : '0;
        state_d  = (&eot_i) ? DONE : RUN;
      end
      RUN: begin
        if (&eot_i) state_d = DONE;
        // The previous owner gets one cycle of grace to finish a beat already in flight.
        if ((mode_q == M_RR || mode_q == M_SEQ) && |(fire_i & ~(en_q | en_prev_q)))
          proto_d = 1'b1;
        if (mode_q == M_RR) begin
          if (eot_i[active_o] || (int'(cnt_q) + int'(beat) >= BURST_LEN)) begin
            active_d = next_gen(active_o, eot_i);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(beat);
          end
        end else if (mode_q == M_SEQ && eot_i[active_o]) begin
          active_d = next_gen(active_o, eot_i);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
    if (state_d != RUN) begin
      active_d = '0;
      rand_d   = 1'b0;
      cnt_d    = '0;
    end
  end

  // Enables are computed from next-state values so outputs line up with active_o.
  always_comb begin
    en_d = '0;
    fv_d = '0;
    if (state_d == RUN) begin
      case (mode_d)
        M_CONC:  en_d = ~eot_i;
        M_FORCE: begin
          en_d = ~eot_i;
          fv_d = ~eot_i;
        end
        default: en_d[active_d] = ~eot_i[active_d];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      mode_q          <= M_CONC;
      cnt_q           <= '0;
      en_prev_q       <= '0;
      force_invalid_o <= '1;
      force_valid_o   <= '0;
      randomize_o     <= 1'b0;
      active_o        <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      proto_err_o     <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      cnt_q           <= cnt_d;
      en_prev_q       <= en_q;
      force_invalid_o <= ~en_d;
      force_valid_o   <= fv_d;
      randomize_o     <= rand_d;
      active_o        <= active_d;
      busy_o          <= (state_d == RUN);
      done_o          <= (state_d == DONE);
      proto_err_o     <= proto_d;
    end
  end

  for (genvar g = 0; g < NB_GEN; g++) begin : g_lane
    localparam logic [15:0] S    = LFSR_SEED ^ 16'(g + 1);
    localparam logic [15:0] SEED = (S == 16'h0000) ? 16'h0001 : S;
    logic [15:0] lfsr_q, lfsr_d;
    logic [9:0]  r_raw, r_map, rng_q;

    always_comb begin
      lfsr_d = SEED;
      if (state_q == RUN) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      r_raw = lfsr_d[9:0];
      r_map = (r_raw >= 10'd1000) ? r_raw - 10'd1000 : r_raw;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        lfsr_q <= SEED;
        rng_q  <= '0;
      end else begin
        lfsr_q <= lfsr_d;
        rng_q  <= (state_d == RUN) ? r_map : 10'd0;
      end
    end

    assign rng_o[g*32 +: 32] = {22'd0, rng_q};
  end

endmodule

// File: tb/tb_hwpe_stream_traffic_sched.sv
// Directed bench for hwpe_stream_traffic_sched: reset, RR bursts, RR with eot skip,
// CONC LFSR numbers, FORCE with abort, SEQ protocol error, start with all eot.
module tb_hwpe_stream_traffic_sched;
  localparam int NB_GEN = 4;
  localparam int BURST_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_ni, start_i, abort_i, randomize_i, auto_fire;
  logic [1:0]  mode_i;
  logic [3:0]  fire_i, eot_i, fire_inj;
  logic [3:0]  force_invalid_o, force_valid_o;
  logic [127:0] rng_o;
  logic        randomize_o, busy_o, done_o, proto_err_o;
  logic [1:0]  active_o;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  // Generators modelled as always-ready, valid whenever not forced invalid.
  assign fire_i = (auto_fire ? ~force_invalid_o : 4'b0000) | fire_inj;

  hwpe_stream_traffic_sched #(.NB_GEN(NB_GEN), .BURST_LEN(BURST_LEN), .LFSR_SEED(16'hACE1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .randomize_i(randomize_i), .fire_i(fire_i), .eot_i(eot_i),
    .force_invalid_o(force_invalid_o), .force_valid_o(force_valid_o), .rng_o(rng_o),
    .randomize_o(randomize_o), .active_o(active_o), .busy_o(busy_o), .done_o(done_o),
    .proto_err_o(proto_err_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m);
    mode_i  = m;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic do_abort();
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
  endtask

  int          rr_exp [26];
  logic [15:0] lfsr;
  logic [9:0]  r;
  logic [31:0] m;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; mode_i = 2'd0; randomize_i = 1'b0;
    eot_i = 4'b0000; fire_inj = 4'b0000; auto_fire = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fi", force_invalid_o, 4'hF);
    check("rst_fv", force_valid_o, 4'h0);
    check("rst_rng", rng_o, 128'd0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_act", active_o, 0);
    check("rst_err", proto_err_o, 0);
    check("rst_rand", randomize_o, 0);

    rst_ni = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_done", done_o, 0);
    end
    check("idle_fi", force_invalid_o, 4'hF);
    check("idle_busy", busy_o, 0);
    check("idle_rng", rng_o, 128'd0);

    // RR, all ready: four beats per turn, 0,1,2,3,0
    auto_fire = 1'b1; randomize_i = 1'b1;
    do_start(2'd1);
    randomize_i = 1'b0;
    check("rr_busy", busy_o, 1);
    check("rr_rand", randomize_o, 1);
    check("rr_fi0", force_invalid_o, 4'b1110);
    for (int c = 0; c < 20; c++) begin
      check("rr_act", active_o, (c / 4) % 4);
      check("rr_fire", fire_i, 4'b0001 << ((c / 4) % 4));
      @(negedge clk);
    end
    check("rr_err", proto_err_o, 0);
    do_abort();
    check("rr_abort_busy", busy_o, 0);
    check("rr_abort_done", done_o, 0);
    check("rr_abort_rand", randomize_o, 0);

    // RR, gen 2 ends on its second beat and is skipped afterwards
    for (int c = 0; c < 26; c++)
      rr_exp[c] = (c < 8) ? c / 4 : (c < 10) ? 2 : (c < 14) ? 3 : (c < 18) ? 0 : (c < 22) ? 1 : 3;
    do_start(2'd1);
    for (int c = 0; c < 26; c++) begin
      check("rre_act", active_o, rr_exp[c]);
      if (c >= 10) check("rre_fi2", force_invalid_o[2], 1);
      if (c == 9) eot_i[2] = 1'b1;
      @(negedge clk);
    end
    eot_i = 4'hF;
    @(negedge clk);
    check("rre_done", done_o, 1);
    check("rre_done_busy", busy_o, 0);
    check("rre_done_fi", force_invalid_o, 4'hF);
    @(negedge clk);
    check("rre_done_pulse", done_o, 0);
    check("rre_err", proto_err_o, 0);
    eot_i = 4'h0;

    // CONC: lane 0 follows the reference LFSR (seed ACE1^1)
    auto_fire = 1'b0;
    do_start(2'd0);
    check("conc_fi", force_invalid_o, 4'h0);
    check("conc_act", active_o, 0);
    check("conc_rng1_first", rng_o[63:32], 32'd227);
    lfsr = 16'hACE0;
    for (int c = 0; c < 20; c++) begin
      r = lfsr[9:0];
      m = (r >= 10'd1000) ? 32'(r - 10'd1000) : 32'(r);
      check("conc_rng0", rng_o[31:0], m);
      check("conc_rng0_range", rng_o[31:0] <= 32'd999, 1);
      if (c == 0) check("conc_rng0_c0", rng_o[31:0], 32'd224);
      if (c == 1) check("conc_rng0_c1", rng_o[31:0], 32'd624);
      if (c == 2) check("conc_rng0_c2", rng_o[31:0], 32'd824);
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      @(negedge clk);
    end
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    check("midrst_fi", force_invalid_o, 4'hF);
    check("midrst_busy", busy_o, 0);
    check("midrst_rng", rng_o, 128'd0);

    // FORCE, abort in the fifth cycle
    do_start(2'd3);
    for (int c = 0; c < 5; c++) begin
      check("force_fv", force_valid_o, 4'hF);
      check("force_fi", force_invalid_o, 4'h0);
      if (c == 4) abort_i = 1'b1;
      @(negedge clk);
    end
    abort_i = 1'b0;
    check("force_ab_fi", force_invalid_o, 4'hF);
    check("force_ab_fv", force_valid_o, 4'h0);
    check("force_ab_busy", busy_o, 0);
    check("force_ab_done", done_o, 0);
    @(negedge clk);
    check("force_ab_done2", done_o, 0);

    // SEQ: no advance on beats, error on stray fire, advance on eot
    auto_fire = 1'b1;
    do_start(2'd2);
    for (int c = 0; c < 6; c++) begin
      check("seq_act", active_o, 0);
      check("seq_err0", proto_err_o, 0);
      @(negedge clk);
    end
    fire_inj = 4'b1000;
    @(negedge clk);
    fire_inj = 4'b0000;
    check("seq_err", proto_err_o, 1);
    eot_i[0] = 1'b1;
    @(negedge clk);
    check("seq_adv", active_o, 1);
    check("seq_adv_fi", force_invalid_o, 4'b1101);
    repeat (3) @(negedge clk);
    check("seq_err_hold", proto_err_o, 1);
    do_abort();
    check("seq_err_abort", proto_err_o, 1);

    // Start with every generator already at eot goes straight to DONE
    eot_i = 4'hF;
    do_start(2'd0);
    check("alleot_done", done_o, 1);
    check("alleot_busy", busy_o, 0);
    check("alleot_err_clr", proto_err_o, 0);
    @(negedge clk);
    check("alleot_done2", done_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
